pipe_ctrl: RTL and testbench

//  Central pipeline controller. Merges stall requests from ID (load-use), EXE (multi-cycle op) and the bus
//  (fetch/data wait) into per-stage stall/flush vectors, and sequences branch/jump redirects from EXE.
//  A redirect raised during a bus stall is held until the stall releases. Sits beside pc/if_id/id_exe/
//  exe_mem/mem_wb; drives their stall/flush pins and the PC redirect.

---
 rtl/pipe_ctrl_if.sv | 28 ++
 rtl/pipe_ctrl.sv | 125 ++++++++++++
 tb/tb_pipe_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and the central pipeline controller.
// The stages side uses the master modport; pipe_ctrl uses the slave modport.
interface pipe_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
);
    logic                  id_stallreq_in;
    logic                  exe_stallreq_in;
    logic                  bus_stallreq_in;
    logic                  jump_req_in;
    logic [ADDR_WIDTH-1:0] jump_addr_in;
    logic [4:0]            stall_out;
    logic [4:0]            flush_out;
    logic                  jump_out;
    logic [ADDR_WIDTH-1:0] jump_addr_out;
    logic                  bus_timeout_out;
    logic [CNT_WIDTH-1:0]  stall_cnt_out;

    modport master (
        output id_stallreq_in, exe_stallreq_in, bus_stallreq_in, jump_req_in, jump_addr_in,
        input  stall_out, flush_out, jump_out, jump_addr_out, bus_timeout_out, stall_cnt_out
    );

    modport slave (
        input  id_stallreq_in, exe_stallreq_in, bus_stallreq_in, jump_req_in, jump_addr_in,
        output stall_out, flush_out, jump_out, jump_addr_out, bus_timeout_out, stall_cnt_out
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: merges ID/EXE/bus stall requests into per-stage stall/flush
// vectors and sequences EXE redirects, deferring a redirect raised during a bus stall.
module pipe_ctrl #(
    parameter int ADDR_WIDTH  = 32,
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_WIDTH   = 32
) (
    input  logic      clk_in,
    input  logic      reset_n_in,
    pipe_ctrl_if.slave pif
);
    localparam int                   RUN_WIDTH   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [RUN_WIDTH-1:0] RUN_LIMIT   = RUN_WIDTH'(TIMEOUT_CYC);
    localparam logic [4:0]           STALL_ALL   = 5'b11111;
    localparam logic [4:0]           STALL_EXE   = 5'b00111;
    localparam logic [4:0]           STALL_ID    = 5'b00011;
    localparam logic [4:0]           FLUSH_REDIR = 5'b00110;
    localparam logic [4:0]           FLUSH_EXE   = 5'b01000;
    localparam logic [4:0]           FLUSH_ID    = 5'b00100;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_HOLD     = 2'b01,
        ST_REDIRECT = 2'b10
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
    logic [RUN_WIDTH-1:0]  bus_run_q, bus_run_d;
    logic                  timeout_q, timeout_d;
    logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;

    logic                  pending_s;
    logic [4:0]            stall_s;
    logic [4:0]            flush_s;
    logic                  jump_s;
    logic [ADDR_WIDTH-1:0] jump_addr_s;

    // Stall/flush priority decode and redirect sequencing; outputs forced quiet while in reset.
    always_comb begin
        state_d     = ST_RUN;
        pend_addr_d = pend_addr_q;
        pending_s   = 1'b0;
        stall_s     = 5'b00000;
        flush_s     = 5'b00000;
        jump_s      = 1'b0;
        jump_addr_s = {ADDR_WIDTH{1'b0}};
        case (state_q)
            ST_HOLD: pending_s = 1'b1;
            default: pending_s = 1'b0;
        endcase
        if (!reset_n_in) begin
            state_d = ST_RUN;
        end else if (pif.bus_stallreq_in) begin
            // First redirect target wins; later requests during the same stall are ignored.
            stall_s = STALL_ALL;
            if (pending_s) begin
                state_d = ST_HOLD;
            end else if (pif.jump_req_in) begin
                state_d     = ST_HOLD;
                pend_addr_d = pif.jump_addr_in;
            end else begin
                state_d = ST_RUN;
            end
        end else if (pending_s || pif.jump_req_in) begin
            flush_s     = FLUSH_REDIR;
            jump_s      = 1'b1;
            jump_addr_s = pending_s ? pend_addr_q : pif.jump_addr_in;
        end else if (pif.exe_stallreq_in) begin
            stall_s = STALL_EXE;
            flush_s = FLUSH_EXE;
        end else if (pif.id_stallreq_in) begin
            stall_s = STALL_ID;
            flush_s = FLUSH_ID;
        end else begin
            stall_s = 5'b00000;
            flush_s = 5'b00000;
        end
    end

    // Bus watchdog run length, sticky timeout flag and saturating stall-cycle counter.
    always_comb begin
        bus_run_d   = {RUN_WIDTH{1'b0}};
        stall_cnt_d = stall_cnt_q;
        if (pif.bus_stallreq_in) begin
            if (bus_run_q == RUN_LIMIT) begin
                bus_run_d = bus_run_q;
            end else begin
                bus_run_d = bus_run_q + RUN_WIDTH'(1);
            end
        end else begin
            bus_run_d = {RUN_WIDTH{1'b0}};
        end
        timeout_d = timeout_q | (bus_run_d == RUN_LIMIT);
        if ((|stall_s) && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State register; reset drops any pending redirect.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q     <= ST_RUN;
            pend_addr_q <= {ADDR_WIDTH{1'b0}};
            bus_run_q   <= {RUN_WIDTH{1'b0}};
            timeout_q   <= 1'b0;
            stall_cnt_q <= {CNT_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            pend_addr_q <= pend_addr_d;
            bus_run_q   <= bus_run_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign pif.stall_out       = stall_s;
    assign pif.flush_out       = flush_s;
    assign pif.jump_out        = jump_s;
    assign pif.jump_addr_out   = jump_addr_s;
    assign pif.bus_timeout_out = timeout_q;
    assign pif.stall_cnt_out   = stall_cnt_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a behavioural model of the controller.
module tb_pipe_ctrl;
    localparam int AW = 32;
    localparam int TO = 4;
    localparam int CW = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk_in     = 1'b0;
    logic reset_n_in = 1'b0;

    pipe_ctrl_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) pif ();

    pipe_ctrl #(.ADDR_WIDTH(AW), .TIMEOUT_CYC(TO), .CNT_WIDTH(CW)) dut (
        .clk_in    (clk_in),
        .reset_n_in(reset_n_in),
        .pif       (pif)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: outstanding redirect, bus run length, sticky timeout, stall cycle count.
    bit          m_pend;
    logic [AW-1:0] m_addr;
    int          m_run;
    bit          m_to;
    int          m_cnt;

    logic [4:0]  e_st, e_fl;
    logic        e_j;
    logic [AW-1:0] e_a;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic b, input logic j, input logic [AW-1:0] a,
                         input logic e, input logic i);
        @(posedge clk_in);
        #1;
        pif.bus_stallreq_in = b;
        pif.jump_req_in     = j;
        pif.jump_addr_in    = a;
        pif.exe_stallreq_in = e;
        pif.id_stallreq_in  = i;
    endtask

    // Compare process: predict from the rules, check, then advance the model to the next edge.
    always @(negedge clk_in) begin
        e_st = 5'b00000; e_fl = 5'b00000; e_j = 1'b0; e_a = '0;
        if (!reset_n_in) begin
            m_pend = 1'b0; m_addr = '0; m_run = 0; m_to = 1'b0; m_cnt = 0;
        end else if (pif.bus_stallreq_in) begin
            e_st = 5'b11111;
        end else if (m_pend || pif.jump_req_in) begin
            e_fl = 5'b00110; e_j = 1'b1;
            e_a  = m_pend ? m_addr : pif.jump_addr_in;
        end else if (pif.exe_stallreq_in) begin
            e_st = 5'b00111; e_fl = 5'b01000;
        end else if (pif.id_stallreq_in) begin
            e_st = 5'b00011; e_fl = 5'b00100;
        end
        chk("stall", 64'(pif.stall_out), 64'(e_st));
        chk("flush", 64'(pif.flush_out), 64'(e_fl));
        chk("jump", 64'(pif.jump_out), 64'(e_j));
        chk("jump_addr", 64'(pif.jump_addr_out), 64'(e_a));
        chk("timeout", 64'(pif.bus_timeout_out), 64'(m_to));
        chk("stall_cnt", 64'(pif.stall_cnt_out), 64'(m_cnt));
        if (reset_n_in) begin
            if (pif.bus_stallreq_in) begin
                if (!m_pend && pif.jump_req_in) begin
                    m_pend = 1'b1;
                    m_addr = pif.jump_addr_in;
                end
                if (m_run < TO) m_run = m_run + 1;
            end else begin
                m_pend = 1'b0;
                m_run  = 0;
            end
            if (m_run >= TO) m_to = 1'b1;
            if (e_st != 5'b00000 && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        end
    end

    initial begin
        bit b, j, e, i;
        pif.bus_stallreq_in = 1'b0;
        pif.jump_req_in     = 1'b0;
        pif.jump_addr_in    = '0;
        pif.exe_stallreq_in = 1'b0;
        pif.id_stallreq_in  = 1'b0;
        @(posedge clk_in);
        @(posedge clk_in);
        #1 reset_n_in = 1'b1;
        #2;
        chk("rst_cnt", 64'(pif.stall_cnt_out), 64'd0);
        chk("rst_to", 64'(pif.bus_timeout_out), 64'd0);

        // Load-use stall
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        #2;
        chk("t2_stall", 64'(pif.stall_out), 64'h03);
        chk("t2_flush", 64'(pif.flush_out), 64'h04);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        chk("t2_cnt", 64'(pif.stall_cnt_out), 64'd1);

        // Redirect beats load-use
        drive(1'b0, 1'b1, 32'h80, 1'b0, 1'b1);
        #2;
        chk("t3_stall", 64'(pif.stall_out), 64'h00);
        chk("t3_flush", 64'(pif.flush_out), 64'h06);
        chk("t3_jump", 64'(pif.jump_out), 64'd1);
        chk("t3_addr", 64'(pif.jump_addr_out), 64'h80);

        // Redirect during bus stall, first target wins, issued once when bus drops
        drive(1'b1, 1'b1, 32'h100, 1'b0, 1'b0);
        #2;
        chk("t4_stall1", 64'(pif.stall_out), 64'h1F);
        chk("t4_jump1", 64'(pif.jump_out), 64'd0);
        drive(1'b1, 1'b1, 32'h200, 1'b0, 1'b0);
        #2;
        chk("t4_jump2", 64'(pif.jump_out), 64'd0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        chk("t4_stall3", 64'(pif.stall_out), 64'h1F);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        chk("t4_jump4", 64'(pif.jump_out), 64'd1);
        chk("t4_addr4", 64'(pif.jump_addr_out), 64'h100);
        chk("t4_flush4", 64'(pif.flush_out), 64'h06);
        chk("t6_to_3cyc", 64'(pif.bus_timeout_out), 64'd0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        chk("t4_once", 64'(pif.jump_out), 64'd0);
        chk("t4_cnt", 64'(pif.stall_cnt_out), 64'd4);

        // EXE stall for four cycles
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
            #2;
            chk("t5_stall", 64'(pif.stall_out), 64'h07);
            chk("t5_flush", 64'(pif.flush_out), 64'h08);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        chk("t5_cnt", 64'(pif.stall_cnt_out), 64'd8);

        // Watchdog: four consecutive bus-stall cycles
        for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        chk("t6_to_set", 64'(pif.bus_timeout_out), 64'd1);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        chk("t6_to_sticky", 64'(pif.bus_timeout_out), 64'd1);

        // Reset mid-HOLD: asynchronous clear, pending redirect dropped
        drive(1'b1, 1'b1, 32'h300, 1'b0, 1'b0);
        @(posedge clk_in);
        #1;
        reset_n_in = 1'b0;
        #1;
        chk("t1_stall", 64'(pif.stall_out), 64'h00);
        chk("t1_jump", 64'(pif.jump_out), 64'd0);
        chk("t1_cnt", 64'(pif.stall_cnt_out), 64'd0);
        chk("t1_to", 64'(pif.bus_timeout_out), 64'd0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        reset_n_in = 1'b1;
        #2;
        chk("t1_nojump", 64'(pif.jump_out), 64'd0);

        // Randomized traffic with bus stall bursts and occasional resets
        b = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (b) b = ($urandom_range(0, 3) != 0);
            else   b = ($urandom_range(0, 5) == 0);
            j = ($urandom_range(0, 4) == 0);
            e = ($urandom_range(0, 4) == 0);
            i = ($urandom_range(0, 4) == 0);
            drive(b, j, AW'($urandom), e, i);
            reset_n_in = ($urandom_range(0, 299) != 0);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        reset_n_in = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        reset_n_in = 1'b1;

        // Stall counter saturates at all-ones
        for (int k = 0; k < 260; k++) drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        chk("cnt_sat", 64'(pif.stall_cnt_out), 64'hFF);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
